// File: rtl/led_pattern_decoder.sv
// Passive monitor for the running-light LED bus: classifies frame-to-frame changes,
// locks onto the active display mode and flags protocol errors on loss of lock.
module led_pattern_decoder #(
  parameter int LOCK_COUNT = 3,
  parameter int INT_M0     = 2,
  parameter int INT_M1     = 8,
  parameter int INT_M2     = 4,
  parameter int INT_M3     = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [25:0] led_in,
  output logic [1:0]  det_mode,
  output logic        locked,
  output logic        mode_change,
  output logic        err,
  output logic [7:0]  match_cnt
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] GAP_M0  = 4'(INT_M0);
  localparam logic [3:0] GAP_M1  = 4'(INT_M1);
  localparam logic [3:0] GAP_M2  = 4'(INT_M2);
  localparam logic [3:0] GAP_M3  = 4'(INT_M3);
  localparam logic [2:0] LOCK_N  = 3'(LOCK_COUNT);

  function automatic logic [4:0] popcount26(input logic [25:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 26; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [3:0] expected_gap(input logic [1:0] mode);
    logic [3:0] g;
    case (mode)
      2'd0:    g = GAP_M0;
      2'd1:    g = GAP_M1;
      2'd2:    g = GAP_M2;
      2'd3:    g = GAP_M3;
      default: g = GAP_M0;
    endcase
    return g;
  endfunction

  state_t      state_r, state_s;
  logic [25:0] prev_led_r;
  logic [3:0]  gap_cnt_r;
  logic        primed_r;
  logic        ever_locked_r;
  logic [1:0]  cand_r, cand_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [1:0]  det_mode_r, det_mode_s;
  logic        locked_r, locked_s;
  logic        mode_change_r, mode_change_s;
  logic        err_r, err_s;
  logic [7:0]  match_cnt_r, match_cnt_s;
  logic        enter_lock_s;

  logic [25:0] diff_s;
  logic        change_s, event_s, upper_zero_s, sym_pair_s, single_bit_s;
  logic        cls_valid_s, timeout_s;
  logic [1:0]  cls_mode_s, ref_mode_s;

  assign diff_s       = led_in ^ prev_led_r;
  assign change_s     = (led_in != prev_led_r);
  assign event_s      = change_s && primed_r;
  assign upper_zero_s = (led_in[25:8] == 18'd0);
  assign single_bit_s = (popcount26(diff_s) == 5'd1);
  assign sym_pair_s   = (diff_s == 26'h81) || (diff_s == 26'h42) ||
                        (diff_s == 26'h24) || (diff_s == 26'h18);
  assign ref_mode_s   = (state_r == LOCKED) ? det_mode_r : cand_r;
  assign timeout_s    = !change_s && (state_r != HUNT) &&
                        (gap_cnt_r > expected_gap(ref_mode_s));

  // Classify the current change by diff shape and interval; first match wins
  always_comb begin
    cls_valid_s = 1'b0;
    cls_mode_s  = 2'd0;
    if (upper_zero_s && ((led_in[7:0] == 8'h55) || (led_in[7:0] == 8'hAA)) &&
        (gap_cnt_r == GAP_M0)) begin
      cls_valid_s = 1'b1;
      cls_mode_s  = 2'd0;
    end else if (upper_zero_s && single_bit_s && (diff_s[25:8] == 18'd0) &&
                 (gap_cnt_r == GAP_M1)) begin
      cls_valid_s = 1'b1;
      cls_mode_s  = 2'd1;
    end else if (upper_zero_s && sym_pair_s && (gap_cnt_r == GAP_M2)) begin
      cls_valid_s = 1'b1;
      cls_mode_s  = 2'd2;
    end else if (single_bit_s && (gap_cnt_r == GAP_M3)) begin
      cls_valid_s = 1'b1;
      cls_mode_s  = 2'd3;
    end else begin
      cls_valid_s = 1'b0;
    end
  end

  // Lock FSM next-state and next-output logic
  always_comb begin
    state_s       = state_r;
    cand_s        = cand_r;
    cnt_s         = cnt_r;
    det_mode_s    = det_mode_r;
    locked_s      = locked_r;
    mode_change_s = 1'b0;
    err_s         = 1'b0;
    match_cnt_s   = match_cnt_r;
    enter_lock_s  = 1'b0;
    case (state_r)
      HUNT: begin
        if (event_s && cls_valid_s) begin
          cand_s = cls_mode_s;
          cnt_s  = 3'd1;
          if (LOCK_N == 3'd1) begin
            enter_lock_s = 1'b1;
          end else begin
            state_s = CONFIRM;
          end
        end else begin
          state_s = HUNT;
        end
      end
      CONFIRM: begin
        if (event_s) begin
          if (cls_valid_s && (cls_mode_s == cand_r)) begin
            cnt_s = cnt_r + 3'd1;
            if (cnt_s == LOCK_N) begin
              enter_lock_s = 1'b1;
            end else begin
              state_s = CONFIRM;
            end
          end else if (cls_valid_s) begin
            cand_s = cls_mode_s;
            cnt_s  = 3'd1;
          end else begin
            state_s = HUNT;
          end
        end else if (timeout_s) begin
          state_s = HUNT;
        end else begin
          state_s = CONFIRM;
        end
      end
      LOCKED: begin
        // A rejected event is consumed here; it does not seed the next hunt
        if (event_s && cls_valid_s && (cls_mode_s == det_mode_r)) begin
          match_cnt_s = match_cnt_r + 8'd1;
        end else if (event_s || timeout_s) begin
          err_s    = 1'b1;
          locked_s = 1'b0;
          state_s  = HUNT;
        end else begin
          state_s = LOCKED;
        end
      end
      default: begin
        state_s  = HUNT;
        locked_s = 1'b0;
      end
    endcase
    if (enter_lock_s) begin
      state_s       = LOCKED;
      det_mode_s    = cand_s;
      locked_s      = 1'b1;
      match_cnt_s   = 8'd0;
      mode_change_s = (cand_s != det_mode_r) || !ever_locked_r;
    end else begin
      mode_change_s = 1'b0;
    end
  end

  // Frame history, interval counter and priming
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prev_led_r <= 26'd0;
      gap_cnt_r  <= 4'd0;
      primed_r   <= 1'b0;
    end else begin
      prev_led_r <= led_in;
      if (change_s) begin
        gap_cnt_r <= 4'd1;
        primed_r  <= 1'b1;
      end else if (gap_cnt_r != 4'd15) begin
        gap_cnt_r <= gap_cnt_r + 4'd1;
      end else begin
        gap_cnt_r <= gap_cnt_r;
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r       <= HUNT;
      cand_r        <= 2'd0;
      cnt_r         <= 3'd0;
      det_mode_r    <= 2'd0;
      locked_r      <= 1'b0;
      mode_change_r <= 1'b0;
      err_r         <= 1'b0;
      match_cnt_r   <= 8'd0;
      ever_locked_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cand_r        <= cand_s;
      cnt_r         <= cnt_s;
      det_mode_r    <= det_mode_s;
      locked_r      <= locked_s;
      mode_change_r <= mode_change_s;
      err_r         <= err_s;
      match_cnt_r   <= match_cnt_s;
      ever_locked_r <= ever_locked_r | enter_lock_s;
    end
  end

  assign det_mode    = det_mode_r;
  assign locked      = locked_r;
  assign mode_change = mode_change_r;
  assign err         = err_r;
  assign match_cnt   = match_cnt_r;

endmodule
